// File: rtl/lfsr_rr_sched_pkg.sv
// Shared definitions for the LFSR round-robin burst scheduler.
//   - state_t      : scheduler FSM states (IDLE, BURST)
//   - LFSR_W, taps : width and feedback taps of the shared Fibonacci LFSR
//   - DEFAULT_SEED : LFSR value loaded on reset (must be non-zero)
//   - lfsr_feedback: feedback bit for a given LFSR value
package lfsr_rr_sched_pkg;

    localparam int REQ_COUNT = 4;
    localparam int ID_W      = 2;
    localparam int CNT_W     = 5;     // holds 1..16 remaining words
    localparam int LFSR_W    = 16;

    localparam int TAP_0 = 15;
    localparam int TAP_1 = 13;
    localparam int TAP_2 = 12;
    localparam int TAP_3 = 10;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'h1001;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] value);
        return value[TAP_0] ^ value[TAP_1] ^ value[TAP_2] ^ value[TAP_3];
    endfunction

endpackage

// File: rtl/lfsr_rr_sched_if.sv
// Request/stream bundle of the LFSR round-robin scheduler.
//   req, burst_len, out_ready : driven by the environment (requesters/consumer)
//   out_valid, out_data, out_id, gnt, busy, done : driven by the scheduler
// The scheduler connects through modport master, the environment through slave.
interface lfsr_rr_sched_if;
    import lfsr_rr_sched_pkg::*;

    logic [REQ_COUNT-1:0] req;
    logic [3:0]           burst_len;
    logic                 out_ready;
    logic                 out_valid;
    logic [LFSR_W-1:0]    out_data;
    logic [ID_W-1:0]      out_id;
    logic [REQ_COUNT-1:0] gnt;
    logic                 busy;
    logic                 done;

    modport master (
        input  req, burst_len, out_ready,
        output out_valid, out_data, out_id, gnt, busy, done
    );

    modport slave (
        output req, burst_len, out_ready,
        input  out_valid, out_data, out_id, gnt, busy, done
    );

endinterface

// File: rtl/lfsr_rr_sched_lfsr_step.sv
// lfsr_step: 16-bit Fibonacci LFSR register that advances by one step when
// en is high, shifting left with the feedback bit entering at bit 0.
//   clk     : clock
//   reset_n : asynchronous active-low reset, loads SEED
//   en      : advance one step on this rising edge
//   value   : current LFSR contents
module lfsr_step
    import lfsr_rr_sched_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] lfsr_reg;
    logic [LFSR_W-1:0] lfsr_next;

    assign lfsr_next[0] = lfsr_feedback(lfsr_reg);

    generate
        for (genvar gi = 1; gi < LFSR_W; gi++) begin : g_shift
            assign lfsr_next[gi] = lfsr_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_reg <= SEED;
        end else if (en) begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign value = lfsr_reg;

endmodule

// File: rtl/lfsr_rr_sched.sv
// lfsr_rr_sched: round-robin arbiter granting one of NUM_REQ requesters a
// burst of words taken from a single shared LFSR.
//   clk     : clock, all state on its rising edge
//   reset_n : asynchronous active-low reset
//   bus     : request/stream bundle (modport master)
//             req/burst_len are sampled only when arbitrating in IDLE;
//             out_valid/out_data/out_id/gnt/busy describe the running burst;
//             done pulses for one cycle after the last word is accepted.
module lfsr_rr_sched
    import lfsr_rr_sched_pkg::*;
#(
    parameter int                NUM_REQ  = REQ_COUNT,
    parameter logic [LFSR_W-1:0] RST_SEED = DEFAULT_SEED
) (
    input  logic            clk,
    input  logic            reset_n,
    lfsr_rr_sched_if.master bus
);

    state_t             state_reg;
    logic [ID_W-1:0]    ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [NUM_REQ-1:0] gnt_reg;
    logic [ID_W-1:0]    out_id_reg;
    logic               out_valid_reg;
    logic               busy_reg;
    logic               done_reg;

    logic [LFSR_W-1:0]  lfsr_value;
    logic               accept;

    // out_valid is only ever high in BURST, so this is the transfer strobe.
    assign accept = out_valid_reg & bus.out_ready;

    lfsr_step #(
        .SEED (RST_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (accept),
        .value   (lfsr_value)
    );

    // Round-robin search: candidate gi is ptr+gi (mod 4); the lowest
    // candidate slot with a pending request wins.
    logic [ID_W-1:0]    cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;
    logic [ID_W-1:0]    winner;
    logic [NUM_REQ-1:0] winner_onehot;
    logic [CNT_W-1:0]   load_count;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand[gi] = ptr_reg + ID_W'(gi);
            assign hit[gi]  = bus.req[cand[gi]];
        end
    endgenerate

    always_comb begin
        winner = cand[0];
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                winner = cand[i];
            end
        end
    end

    assign winner_onehot = NUM_REQ'(1) << winner;

    // A burst_len of zero encodes the maximum burst of 16 words.
    assign load_count = (bus.burst_len == 4'd0) ? CNT_W'(16) : {1'b0, bus.burst_len};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            count_reg     <= '0;
            gnt_reg       <= '0;
            out_id_reg    <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|bus.req) begin
                        gnt_reg       <= winner_onehot;
                        out_id_reg    <= winner;
                        count_reg     <= load_count;
                        out_valid_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= BURST;
                    end
                end
                BURST: begin
                    // req and burst_len are deliberately not looked at here:
                    // a granted burst always runs to completion.
                    if (accept) begin
                        count_reg <= count_reg - CNT_W'(1);
                        if (count_reg == CNT_W'(1)) begin
                            gnt_reg       <= '0;
                            out_valid_reg <= 1'b0;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                            ptr_reg       <= out_id_reg + ID_W'(1);
                            state_reg     <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.out_id    = out_id_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.out_data  = lfsr_value;

endmodule

// File: tb/tb_lfsr_rr_sched.sv
// Testbench for lfsr_rr_sched: a table of per-cycle vectors covering the
// first burst after reset and round-robin rotation, then hand-written
// sequences for stalls, the 16-word burst, request drop and reset mid-burst.
module tb_lfsr_rr_sched;
    import lfsr_rr_sched_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    lfsr_rr_sched_if bus ();

    lfsr_rr_sched #(
        .NUM_REQ  (4),
        .RST_SEED (16'h1001)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_word;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  bl;
        logic        rdy;
        logic [3:0]  gnt;
        logic        valid;
        logic [15:0] data;
        logic [1:0]  id;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs [15];

    function automatic logic [15:0] lfsr_ref(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] gnt, input logic valid,
                           input logic [15:0] data, input logic [1:0] id,
                           input logic busy, input logic done);
        chk({tag, ".gnt"},   32'(bus.gnt),       32'(gnt));
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(valid));
        chk({tag, ".data"},  32'(bus.out_data),  32'(data));
        chk({tag, ".id"},    32'(bus.out_id),    32'(id));
        chk({tag, ".busy"},  32'(bus.busy),      32'(busy));
        chk({tag, ".done"},  32'(bus.done),      32'(done));
        chk({tag, ".onehot"}, 32'($onehot0(bus.gnt)), 32'd1);
        $display("%s: gnt=%b valid=%b data=%h id=%0d busy=%b done=%b",
                 tag, bus.gnt, bus.out_valid, bus.out_data, bus.out_id, bus.busy, bus.done);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs an already-granted burst until done, checking every accepted word
    // against the reference LFSR and the word count; req/burst_len are
    // scrambled after drop_after words to show they are ignored.
    task automatic drain(input string tag, input int exp_beats, input logic [1:0] exp_id,
                         input int drop_after);
        int beats = 0;
        bit seen_done = 1'b0;
        for (int cyc = 0; cyc < 48; cyc++) begin
            if (bus.done) begin
                seen_done = 1'b1;
                break;
            end
            if (bus.out_valid && bus.out_ready) begin
                chk({tag, ".word"}, 32'(bus.out_data), 32'(exp_word));
                chk({tag, ".id"},   32'(bus.out_id),   32'(exp_id));
                exp_word = lfsr_ref(exp_word);
                beats++;
                if (beats == drop_after) begin
                    bus.req       = 4'b0000;
                    bus.burst_len = 4'd7;
                end
            end
            step();
        end
        chk({tag, ".done_seen"}, 32'(seen_done), 32'd1);
        chk({tag, ".beats"},     32'(beats),     32'(exp_beats));
        chk({tag, ".gnt_clr"},   32'(bus.gnt),   32'd0);
        chk({tag, ".busy_clr"},  32'(bus.busy),  32'd0);
        $display("%s: burst of %0d words from id %0d ended, next word %h",
                 tag, beats, exp_id, bus.out_data);
    endtask

    initial begin
        // req, bl, rdy | gnt, valid, data, id, busy, done
        vecs[0]  = '{4'b0000, 4'd3, 1'b1, 4'b0000, 1'b0, 16'h1001, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{4'b0001, 4'd3, 1'b1, 4'b0001, 1'b1, 16'h1001, 2'd0, 1'b1, 1'b0};
        vecs[2]  = '{4'b0000, 4'd9, 1'b1, 4'b0001, 1'b1, 16'h2003, 2'd0, 1'b1, 1'b0};
        vecs[3]  = '{4'b0000, 4'd3, 1'b1, 4'b0001, 1'b1, 16'h4007, 2'd0, 1'b1, 1'b0};
        vecs[4]  = '{4'b0000, 4'd3, 1'b1, 4'b0000, 1'b0, 16'h800E, 2'd0, 1'b0, 1'b1};
        vecs[5]  = '{4'b0000, 4'd3, 1'b1, 4'b0000, 1'b0, 16'h800E, 2'd0, 1'b0, 1'b0};
        vecs[6]  = '{4'b1111, 4'd1, 1'b1, 4'b0010, 1'b1, 16'h800E, 2'd1, 1'b1, 1'b0};
        vecs[7]  = '{4'b1111, 4'd1, 1'b1, 4'b0000, 1'b0, 16'h001D, 2'd1, 1'b0, 1'b1};
        vecs[8]  = '{4'b1111, 4'd1, 1'b1, 4'b0100, 1'b1, 16'h001D, 2'd2, 1'b1, 1'b0};
        vecs[9]  = '{4'b1111, 4'd1, 1'b1, 4'b0000, 1'b0, 16'h003A, 2'd2, 1'b0, 1'b1};
        vecs[10] = '{4'b1111, 4'd1, 1'b1, 4'b1000, 1'b1, 16'h003A, 2'd3, 1'b1, 1'b0};
        vecs[11] = '{4'b1111, 4'd1, 1'b1, 4'b0000, 1'b0, 16'h0074, 2'd3, 1'b0, 1'b1};
        vecs[12] = '{4'b1111, 4'd1, 1'b1, 4'b0001, 1'b1, 16'h0074, 2'd0, 1'b1, 1'b0};
        vecs[13] = '{4'b0000, 4'd1, 1'b1, 4'b0000, 1'b0, 16'h00E8, 2'd0, 1'b0, 1'b1};
        vecs[14] = '{4'b0000, 4'd1, 1'b1, 4'b0000, 1'b0, 16'h00E8, 2'd0, 1'b0, 1'b0};

        reset_n       = 1'b0;
        bus.req       = 4'b0000;
        bus.burst_len = 4'd0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk_all("reset", 4'b0000, 1'b0, 16'h1001, 2'd0, 1'b0, 1'b0);
        reset_n = 1'b1;

        // Table: first burst after reset, then round-robin 1,2,3,0 with gaps.
        for (int i = 0; i < 15; i++) begin
            bus.req       = vecs[i].req;
            bus.burst_len = vecs[i].bl;
            bus.out_ready = vecs[i].rdy;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].valid, vecs[i].data,
                    vecs[i].id, vecs[i].busy, vecs[i].done);
        end

        // Stall: 2-word burst to requester 1 with out_ready low for 3 cycles.
        bus.req       = 4'b0010;
        bus.burst_len = 4'd2;
        bus.out_ready = 1'b1;
        step();
        chk_all("stall.grant", 4'b0010, 1'b1, 16'h00E8, 2'd1, 1'b1, 1'b0);
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all($sformatf("stall.hold%0d", k), 4'b0010, 1'b1, 16'h00E8, 2'd1, 1'b1, 1'b0);
        end
        bus.out_ready = 1'b1;
        step();
        chk_all("stall.word2", 4'b0010, 1'b1, 16'h01D0, 2'd1, 1'b1, 1'b0);
        step();
        chk_all("stall.end", 4'b0000, 1'b0, 16'h03A0, 2'd1, 1'b0, 1'b1);
        step();
        chk_all("stall.gap", 4'b0000, 1'b0, 16'h03A0, 2'd1, 1'b0, 1'b0);
        exp_word = 16'h03A0;

        // burst_len 0 means 16 words; ptr is now 2.
        bus.req       = 4'b0100;
        bus.burst_len = 4'd0;
        step();
        chk("b16.gnt", 32'(bus.gnt), 32'b0100);
        bus.req       = 4'b0000;
        bus.burst_len = 4'd3;
        drain("b16", 16, 2'd2, 0);
        step();

        // req[2] drops after the first word of a 4-word burst.
        bus.req       = 4'b0100;
        bus.burst_len = 4'd4;
        step();
        chk("drop.gnt", 32'(bus.gnt), 32'b0100);
        drain("drop", 4, 2'd2, 1);
        step();

        // Reset mid-burst (ptr is 3, so requester 0 wins).
        bus.req       = 4'b0001;
        bus.burst_len = 4'd5;
        step();
        chk("rst.gnt", 32'(bus.gnt), 32'b0001);
        step();
        chk("rst.word2", 32'(bus.out_data), 32'(lfsr_ref(exp_word)));
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("rst.async", 4'b0000, 1'b0, 16'h1001, 2'd0, 1'b0, 1'b0);
        step();
        reset_n       = 1'b1;
        bus.burst_len = 4'd1;
        step();
        chk_all("rst.first", 4'b0001, 1'b1, 16'h1001, 2'd0, 1'b1, 1'b0);
        bus.req = 4'b0000;
        step();
        chk_all("rst.done", 4'b0000, 1'b0, 16'h2003, 2'd0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
